seq_sign_mag_multiplier: RTL and testbench

Parametrised iterative sign-magnitude multiplier: the next generation of the sign-only product unit, which only produced the XOR of two operand signs. It computes both the product sign and the full-width unsigned product of two magnitudes with a shift-add datapath, one multiplier bit per clock. It uses a start/busy/done handshake and sits in the arithmetic datapath feeding the mantissa/normalisation stage.

---
 rtl/seq_sign_mag_multiplier.sv | 127 ++++++++++++
 tb/tb_seq_sign_mag_multiplier.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_sign_mag_multiplier.sv
// Iterative sign-magnitude multiplier: shift-add datapath,
// one multiplier bit per clock, start/busy/done handshake.
module seq_sign_mag_multiplier #(
  parameter int WIDTH           = 8,
  parameter bit ZERO_SIGN_CLEAR = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               X_signal,
  input  logic [WIDTH-1:0]   X_mag,
  input  logic               Y_signal,
  input  logic [WIDTH-1:0]   Y_mag,
  output logic               busy,
  output logic               done,
  output logic               Mult_signal,
  output logic [2*WIDTH-1:0] P_mag
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic               xs_q, xs_d;
  logic               ys_q, ys_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   wide;
  logic [2*WIDTH-1:0] acc_sh;
  logic               last;

  always_comb begin
    // partial sum keeps its carry in the top bit before the shift
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
           + {1'b0, (mplier_q[0] ? mcand_q : '0)};
    wide   = {sum, acc_q[WIDTH-1:0]};
    acc_sh = (2*WIDTH)'(wide >> 1);
    last   = (cnt_q == CW'(WIDTH - 1));

    state_d  = state_q;
    xs_d     = xs_q;
    ys_d     = ys_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          xs_d     = X_signal;
          ys_d     = Y_signal;
          mcand_d  = X_mag;
          mplier_d = Y_mag;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        acc_d    = acc_sh;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          p_d     = acc_sh;
          sign_d  = (xs_q ^ ys_q)
                  & ~(ZERO_SIGN_CLEAR && (acc_sh == '0));
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      xs_q     <= 1'b0;
      ys_q     <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      xs_q     <= xs_d;
      ys_q     <= ys_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign Mult_signal = sign_q;
  assign P_mag       = p_q;

endmodule

// File: tb/tb_seq_sign_mag_multiplier.sv
// Random + directed bench for seq_sign_mag_multiplier against
// a cycle-level behavioural model of the handshake and product.
module tb_seq_sign_mag_multiplier;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        xs = 1'b0, ys = 1'b0;
  logic [7:0]  xm = '0, ym = '0;
  logic        busy, done, ms;
  logic [15:0] pm;
  logic        busy0, done0, ms0;
  logic [15:0] pm0;

  logic        start16 = 1'b0;
  logic        xs16 = 1'b0, ys16 = 1'b1;
  logic [15:0] xm16 = '0, ym16 = '0;
  logic        busy16, done16, ms16;
  logic [31:0] pm16;

  always #5 clk = ~clk;

  seq_sign_mag_multiplier #(.WIDTH(8), .ZERO_SIGN_CLEAR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .X_signal(xs), .X_mag(xm), .Y_signal(ys), .Y_mag(ym),
    .busy(busy), .done(done), .Mult_signal(ms), .P_mag(pm)
  );

  seq_sign_mag_multiplier #(.WIDTH(8), .ZERO_SIGN_CLEAR(1'b0)) dut_z (
    .clk(clk), .rst_n(rst_n), .start(start),
    .X_signal(xs), .X_mag(xm), .Y_signal(ys), .Y_mag(ym),
    .busy(busy0), .done(done0), .Mult_signal(ms0), .P_mag(pm0)
  );

  seq_sign_mag_multiplier #(.WIDTH(16), .ZERO_SIGN_CLEAR(1'b1)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16),
    .X_signal(xs16), .X_mag(xm16), .Y_signal(ys16), .Y_mag(ym16),
    .busy(busy16), .done(done16), .Mult_signal(ms16), .P_mag(pm16)
  );

  int vec = 0;
  int err = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // model: an operation accepted at edge a is busy through a+W,
  // done at a+W, and frees the unit at a+W+1
  int          n = 0, a = 0;
  bit          infl = 1'b0;
  logic [7:0]  mx = '0, my = '0;
  bit          mxs = 1'b0, mys = 1'b0;
  logic [15:0] e_p = '0;
  bit          e_s = 1'b0, e_s0 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl = 1'b0;
      e_p  = '0;
      e_s  = 1'b0;
      e_s0 = 1'b0;
      n    = 0;
    end else begin
      n++;
      if (!infl) begin
        if (start) begin
          infl = 1'b1;
          a    = n;
          mx   = xm;
          my   = ym;
          mxs  = xs;
          mys  = ys;
        end
      end else begin
        if (n - a == W) begin
          e_p  = {8'b0, mx} * {8'b0, my};
          e_s0 = mxs ^ mys;
          e_s  = (e_p == 0) ? 1'b0 : (mxs ^ mys);
        end
        if (n - a == W + 1) infl = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", busy, infl);
      check("done", done, infl && (n - a == W));
      check("P_mag", pm, e_p);
      check("Mult_signal", ms, e_s);
      check("P_mag_z0", pm0, e_p);
      check("Mult_signal_z0", ms0, e_s0);
    end
  end

  task automatic run(input bit s1, input logic [7:0] x,
                     input bit s2, input logic [7:0] y);
    int c;
    @(negedge clk);
    xs = s1; xm = x; ys = s2; ym = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    xs = 1'($urandom); xm = 8'($urandom);
    ys = 1'($urandom); ym = 8'($urandom);
    c = 0;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("latency", c, W);
    @(negedge clk);
    check("done_width", done, 0);
  endtask

  initial begin : timeout
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  bit sgn_tab [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int cnt, t_prev, ivl, c;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_P", pm, 0);
    check("rst_sign", ms, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run(i[0], 8'd3, i[1], 8'd4);
      check("sign_tab_P", pm, 12);
      check("sign_tab_S", ms, sgn_tab[i]);
    end

    run(1'b0, 8'd255, 1'b0, 8'd255);
    check("corner_255x255", pm, 16'hFE01);
    run(1'b0, 8'd1, 1'b1, 8'd255);
    check("corner_1x255", pm, 16'h00FF);
    check("corner_1x255_S", ms, 1);
    run(1'b1, 8'd128, 1'b1, 8'd2);
    check("corner_128x2", pm, 16'h0100);

    run(1'b1, 8'd0, 1'b0, 8'd9);
    check("zero_P", pm, 0);
    check("zero_S_clr", ms, 0);
    check("zero_S_raw", ms0, 1);

    run(1'b0, 8'd13, 1'b1, 8'd11);
    check("captured_ops", pm, 143);
    check("captured_S", ms, 1);

    // stray start pulses during RUN and DONE
    @(negedge clk);
    xs = 1'b0; xm = 8'd7; ys = 1'b0; ym = 8'd5; start = 1'b1;
    cnt = 0;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      start = (j == 3 || j == 9);
      if (done) cnt++;
    end
    start = 1'b0;
    check("ignored_start_dones", cnt, 1);
    check("ignored_start_P", pm, 35);

    // start held high
    @(negedge clk);
    xm = 8'd5; ym = 8'd6; start = 1'b1;
    cnt = 0; t_prev = 0; ivl = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (done) begin
        if (cnt == 1) ivl = j - t_prev;
        t_prev = j;
        cnt++;
      end
    end
    start = 1'b0;
    check("held_dones", cnt, 4);
    check("held_interval", ivl, 10);
    c = 0;
    while (busy && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("held_drain", busy, 0);

    for (int i = 0; i < 200; i++) begin
      run(1'($urandom),
          ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom),
          1'($urandom),
          ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom));
    end

    // asynchronous reset mid-RUN
    run(1'b1, 8'd200, 1'b0, 8'd3);
    @(negedge clk);
    xm = 8'd9; ym = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_P", pm, 0);
    check("async_S", ms, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run(1'b1, 8'd6, 1'b0, 8'd7);
    check("post_rst_P", pm, 42);
    check("post_rst_S", ms, 1);

    @(negedge clk);
    xm16 = 16'hFFFF; ym16 = 16'hFFFF; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    c = 0;
    while (!done16 && c < 60) begin
      @(negedge clk);
      c++;
    end
    check("w16_latency", c, 16);
    check("w16_P", pm16, 32'hFFFE0001);
    check("w16_S", ms16, 1);
    @(negedge clk);
    check("w16_done_width", done16, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
